// File: rtl/d_fork_pkg.sv
// Shared types and limits for the d_fork eager elastic fork.
package d_fork_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int MAX_NUM_OUT = 8;

  typedef logic [DATA_WIDTH-1:0]  token_t;
  typedef logic [MAX_NUM_OUT-1:0] out_mask_t;
endpackage

// File: rtl/d_fork.sv
// Eager fork: one registered token fanned out to NUM_OUT consumers; retires once every enabled consumer has taken it.
// Latency 1 cycle, full throughput; io_din_r is combinational from io_dout_r. Optional D_FORK_STATS_EN adds io_tok_cnt.
module d_fork
  import d_fork_pkg::*;
#(
  parameter int DATA_WIDTH = d_fork_pkg::DATA_WIDTH,
  parameter int NUM_OUT    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         io_din,
  input  logic                          io_din_v,
  output logic                          io_din_r,
  input  logic [NUM_OUT-1:0]            io_mask,
  output logic [NUM_OUT*DATA_WIDTH-1:0] io_dout,
  output logic [NUM_OUT-1:0]            io_dout_v,
  input  logic [NUM_OUT-1:0]            io_dout_r
`ifdef D_FORK_STATS_EN
  ,
  output logic [31:0]                   io_tok_cnt
`endif
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_OUT-1:0]    pend_q, pend_d;
  logic                  done;
  logic                  accept;

  // Nothing held, or every outstanding consumer takes the token this cycle.
  assign done     = ((pend_q & ~io_dout_r) == '0);
  assign io_din_r = done && !reset;
  assign accept   = io_din_v && io_din_r;

  assign io_dout_v = pend_q;
  assign io_dout   = {NUM_OUT{data_q}};

  always_comb begin
    pend_d = pend_q & ~io_dout_r;
    data_d = data_q;
    if (accept) begin
      pend_d = io_mask;
      data_d = io_din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

`ifdef D_FORK_STATS_EN
  logic [31:0] tok_cnt_q, tok_cnt_d;
  logic        retire_held;
  logic        retire_drop;

  // A held token and a dropped (mask==0) token can both retire in one cycle.
  assign retire_held = (pend_q != '0) && done;
  assign retire_drop = accept && (io_mask == '0);

  always_comb begin
    tok_cnt_d = tok_cnt_q + 32'(retire_held) + 32'(retire_drop);
  end

  always_ff @(posedge clock) begin
    if (reset) tok_cnt_q <= '0;
    else       tok_cnt_q <= tok_cnt_d;
  end

  assign io_tok_cnt = tok_cnt_q;
`endif

endmodule

// File: tb/tb_d_fork.sv
// Directed self-checking bench for d_fork (NUM_OUT=4, DATA_WIDTH=32).
module tb_d_fork;
  import d_fork_pkg::*;

  localparam int DW = 32;
  localparam int NO = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [DW-1:0]      io_din;
  logic               io_din_v;
  logic               io_din_r;
  logic [NO-1:0]      io_mask;
  logic [NO*DW-1:0]   io_dout;
  logic [NO-1:0]      io_dout_v;
  logic [NO-1:0]      io_dout_r;
`ifdef D_FORK_STATS_EN
  logic [31:0]        io_tok_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  d_fork #(.DATA_WIDTH(DW), .NUM_OUT(NO)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_din    (io_din),
    .io_din_v  (io_din_v),
    .io_din_r  (io_din_r),
    .io_mask   (io_mask),
    .io_dout   (io_dout),
    .io_dout_v (io_dout_v),
    .io_dout_r (io_dout_r)
`ifdef D_FORK_STATS_EN
    ,
    .io_tok_cnt(io_tok_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    token_t t;
    reset     = 1'b1;
    io_din    = '0;
    io_din_v  = 1'b0;
    io_mask   = '0;
    io_dout_r = '0;
    tick();
    tick();
    chk("rst_dout_v", 128'(io_dout_v), 128'h0);
    chk("rst_dout",   128'(io_dout),   128'h0);
    chk("rst_din_r",  128'(io_din_r),  128'h0);
`ifdef D_FORK_STATS_EN
    chk("rst_cnt", 128'(io_tok_cnt), 128'h0);
`endif
    reset = 1'b0;
    #1 chk("post_rst_din_r", 128'(io_din_r), 128'h1);

    // Full-rate broadcast of 1,2,3.
    io_mask   = 4'b1111;
    io_dout_r = 4'b1111;
    for (int k = 1; k <= 3; k++) begin
      io_din   = DW'(k);
      io_din_v = 1'b1;
      #1 chk("stream_din_r", 128'(io_din_r), 128'h1);
      tick();
      t = token_t'(k);
      chk("stream_v",   128'(io_dout_v), 128'hF);
      chk("stream_dat", 128'(io_dout),   128'({4{t}}));
    end
    io_din_v = 1'b0;
    tick();
    chk("stream_drain", 128'(io_dout_v), 128'h0);

    // Partial delivery with mask 0101.
    io_mask   = 4'b0101;
    io_din    = 32'hA5A5A5A5;
    io_din_v  = 1'b1;
    io_dout_r = 4'b0000;
    tick();
    io_din_v = 1'b0;
    chk("part_v0", 128'(io_dout_v), 128'h5);
    io_dout_r = 4'b0001;
    #1 chk("part_din_r0", 128'(io_din_r), 128'h0);
    tick();
    chk("part_v1", 128'(io_dout_v), 128'h4);
    chk("part_din_r1", 128'(io_din_r), 128'h0);
    tick();
    chk("part_v2", 128'(io_dout_v), 128'h4);
    chk("part_dat2", 128'(io_dout[2*DW +: DW]), 128'hA5A5A5A5);
    io_dout_r = 4'b0100;
    #1 chk("part_din_r2", 128'(io_din_r), 128'h1);
    tick();
    chk("part_v3", 128'(io_dout_v), 128'h0);

    // Mask change while holding; new token loads with no bubble.
    io_mask   = 4'b0011;
    io_din    = 32'h55;
    io_din_v  = 1'b1;
    io_dout_r = 4'b0000;
    tick();
    io_din_v = 1'b0;
    io_mask  = 4'b1100;
    chk("hold_v0", 128'(io_dout_v), 128'h3);
    tick();
    chk("hold_v1", 128'(io_dout_v), 128'h3);
    chk("hold_dat", 128'(io_dout[0 +: DW]), 128'h55);
    io_dout_r = 4'b1111;
    io_din    = 32'h66;
    io_din_v  = 1'b1;
    #1 chk("hold_din_r", 128'(io_din_r), 128'h1);
    tick();
    io_din_v = 1'b0;
    chk("next_v", 128'(io_dout_v), 128'hC);
    chk("next_dat", 128'(io_dout[2*DW +: DW]), 128'h66);
    tick();
    chk("next_drain", 128'(io_dout_v), 128'h0);
`ifdef D_FORK_STATS_EN
    chk("cnt_before_drop", 128'(io_tok_cnt), 128'd6);
`endif

    // Drop with mask 0.
    io_mask   = 4'b0000;
    io_din    = 32'h77;
    io_din_v  = 1'b1;
    io_dout_r = 4'b0000;
    #1 chk("drop_din_r", 128'(io_din_r), 128'h1);
    tick();
    io_din_v = 1'b0;
    chk("drop_v", 128'(io_dout_v), 128'h0);
`ifdef D_FORK_STATS_EN
    chk("drop_cnt", 128'(io_tok_cnt), 128'd7);
`endif

    // Reset discards a partially delivered token.
    io_mask  = 4'b1111;
    io_din   = 32'hDEAD;
    io_din_v = 1'b1;
    tick();
    io_din_v  = 1'b0;
    io_dout_r = 4'b0001;
    tick();
    chk("dead_v", 128'(io_dout_v), 128'hE);
    io_dout_r = 4'b0000;
    reset     = 1'b1;
    #1 chk("mid_rst_din_r0", 128'(io_din_r), 128'h0);
    tick();
    chk("mid_rst_v",     128'(io_dout_v), 128'h0);
    chk("mid_rst_dout",  128'(io_dout),   128'h0);
    chk("mid_rst_din_r", 128'(io_din_r),  128'h0);
    reset = 1'b0;
    #1 chk("after_rst_din_r", 128'(io_din_r), 128'h1);
    tick();
    chk("after_rst_v",    128'(io_dout_v), 128'h0);
    chk("after_rst_dout", 128'(io_dout),   128'h0);
`ifdef D_FORK_STATS_EN
    chk("after_rst_cnt", 128'(io_tok_cnt), 128'h0);

    // Counter wrap.
    force dut.tok_cnt_q = 32'hFFFFFFFF;
    #1 release dut.tok_cnt_q;
    io_mask   = 4'b0001;
    io_din    = 32'h1;
    io_din_v  = 1'b1;
    io_dout_r = 4'b0001;
    tick();
    io_din_v = 1'b0;
    chk("wrap_pre", 128'(io_tok_cnt), 128'hFFFFFFFF);
    tick();
    chk("wrap_cnt", 128'(io_tok_cnt), 128'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
